// File: rtl/select_pipe_pkg.sv
// Shared types and the lane-extension helper for the select_pipe datapath.
// MAX_W bounds the widest output any instance may request.
package select_pipe_pkg;

  localparam int MAX_W = 64;

  typedef struct packed {
    logic [MAX_W-1:0] data;
    logic             oor;
  } stage_t;

  // Bits at and above in_w are filled with the lane's sign bit when is_signed,
  // otherwise with zero.
  function automatic logic [MAX_W-1:0] extend(input logic [MAX_W-1:0] data,
                                              input int unsigned      in_w,
                                              input logic             is_signed);
    logic [MAX_W-1:0] hi_mask;
    logic             fill;
    hi_mask = {MAX_W{1'b1}} << in_w;
    fill    = is_signed & (|(data & (hi_mask >> 1) & ~hi_mask));
    return (data & ~hi_mask) | (fill ? hi_mask : '0);
  endfunction

endpackage

// File: rtl/select_pipe_if.sv
// Request/response bundle for select_pipe; master drives requests, slave is the pipe.
interface select_pipe_if #(
  parameter int NUM_IN = 4,
  parameter int IN_W   = 4,
  parameter int OUT_W  = 5,
  parameter int SEL_W  = 3,
  parameter int CNT_W  = 8
);
  logic                   in_valid;
  logic                   in_ready;
  logic [SEL_W-1:0]       in_sel;
  logic [NUM_IN*IN_W-1:0] in_data;
  logic                   out_valid;
  logic                   out_ready;
  logic [OUT_W-1:0]       out_data;
  logic                   out_oor;
  logic [CNT_W-1:0]       oor_cnt;
  logic                   clr_cnt;

  modport master (
    output in_valid, in_sel, in_data, out_ready, clr_cnt,
    input  in_ready, out_valid, out_data, out_oor, oor_cnt
  );

  modport slave (
    input  in_valid, in_sel, in_data, out_ready, clr_cnt,
    output in_ready, out_valid, out_data, out_oor, oor_cnt
  );
endinterface

// File: rtl/select_pipe_skid_buffer.sv
// Two-entry valid/ready register slice: an output register plus one skid entry,
// so upstream ready is a flop and never sees downstream ready combinationally.
module skid_buffer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] in_data_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] out_data_o
);

  logic             out_vld_q, out_vld_d;
  logic             skid_vld_q, skid_vld_d;
  logic [WIDTH-1:0] out_dat_q, out_dat_d;
  logic [WIDTH-1:0] skid_dat_q, skid_dat_d;
  logic             in_fire;

  assign in_fire = in_valid_i & ~skid_vld_q;

  // A full skid entry implies a full output register, so it only waits for a drain.
  always_comb begin
    out_vld_d  = out_vld_q;
    out_dat_d  = out_dat_q;
    skid_vld_d = skid_vld_q;
    skid_dat_d = skid_dat_q;
    if (skid_vld_q) begin
      if (out_ready_i) begin
        out_dat_d  = skid_dat_q;
        skid_vld_d = 1'b0;
      end
    end else if (in_fire) begin
      if (!out_vld_q || out_ready_i) begin
        out_vld_d = 1'b1;
        out_dat_d = in_data_i;
      end else begin
        skid_vld_d = 1'b1;
        skid_dat_d = in_data_i;
      end
    end else if (out_ready_i) begin
      out_vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_vld_q  <= 1'b0;
      skid_vld_q <= 1'b0;
      out_dat_q  <= '0;
    end else begin
      out_vld_q  <= out_vld_d;
      skid_vld_q <= skid_vld_d;
      out_dat_q  <= out_dat_d;
    end
  end

  always_ff @(posedge clk) begin
    skid_dat_q <= skid_dat_d;
  end

  assign in_ready_o  = ~skid_vld_q;
  assign out_valid_o = out_vld_q;
  assign out_data_o  = out_dat_q;

endmodule

// File: rtl/select_pipe.sv
// N-way selector: picks one lane, sign/zero-extends it to OUT_W, and hands it to a
// registered skid stage; out-of-range codes yield zero data and bump a saturating counter.
module select_pipe
  import select_pipe_pkg::*;
#(
  parameter int              NUM_IN      = 4,
  parameter int              IN_W        = 4,
  parameter int              OUT_W       = 5,
  parameter int              SEL_W       = 3,
  parameter logic [NUM_IN-1:0] SIGNED_MASK = 4'b1100,
  parameter int              CNT_W       = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  select_pipe_if.slave  bus
);

  if (OUT_W < IN_W) begin : g_chk_out_w
    $error("select_pipe: OUT_W must be >= IN_W");
  end
  if (OUT_W >= MAX_W) begin : g_chk_max_w
    $error("select_pipe: OUT_W must be below select_pipe_pkg::MAX_W");
  end
  if (NUM_IN < 2) begin : g_chk_num_in
    $error("select_pipe: NUM_IN must be >= 2");
  end

  stage_t           stage_p0;
  logic [OUT_W:0]   pay_p0;
  logic [OUT_W:0]   pay_p1;
  logic             unused_hi;
  logic             oor_acc;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Stage 0: combinational lane select and extension; unmatched codes stay zero/oor.
  always_comb begin
    stage_p0      = '0;
    stage_p0.oor  = 1'b1;
    for (int i = 0; i < NUM_IN; i++) begin
      if (int'(bus.in_sel) == i) begin
        stage_p0.oor  = 1'b0;
        stage_p0.data = extend(MAX_W'(bus.in_data[i*IN_W +: IN_W]), IN_W, SIGNED_MASK[i]);
      end
    end
  end

  assign pay_p0    = {stage_p0.data[OUT_W-1:0], stage_p0.oor};
  assign unused_hi = |stage_p0.data[MAX_W-1:OUT_W];

  // Stage 1: registered output with skid entry.
  skid_buffer #(
    .WIDTH (OUT_W + 1)
  ) u_skid (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid_i  (bus.in_valid),
    .in_ready_o  (bus.in_ready),
    .in_data_i   (pay_p0),
    .out_valid_o (bus.out_valid),
    .out_ready_i (bus.out_ready),
    .out_data_o  (pay_p1)
  );

  assign bus.out_data = pay_p1[OUT_W:1];
  assign bus.out_oor  = pay_p1[0];

  // Counted on the input handshake so a stalled output does not delay the count.
  assign oor_acc = bus.in_valid & bus.in_ready & stage_p0.oor;

  always_comb begin
    cnt_d = cnt_q;
    if (bus.clr_cnt) begin
      cnt_d = oor_acc ? CNT_W'(1) : '0;
    end else if (oor_acc && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign bus.oor_cnt = cnt_q;

endmodule
